// File: rtl/msk_demod.sv
// Coherent MSK demodulator: NCO mixing, staggered I/Q integrate-and-dump, sign slicing and
// serialisation of the decisions as I, Q, I, Q ...
module msk_demod #(
    parameter int unsigned SPB       = 50,
    parameter logic [31:0] PHASE_INC = 32'h4000_0000,
    parameter int unsigned ACC_W     = 24
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               sync,
    input  logic signed [32:0] msk_in,
    output logic               bit_out,
    output logic               bit_valid,
    output logic               b_i,
    output logic               b_q
);

    localparam int unsigned WIN = 2 * SPB;
    localparam int unsigned CW  = $clog2(WIN);

    // Quarter-wave table of round(32767 * sin(2*pi*k/64)); the full 64-entry ROM is folded onto it.
    function automatic logic signed [15:0] sine(input logic [5:0] idx);
        logic [4:0]         qi;
        logic signed [15:0] mag;
        qi = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
        case (qi)
            5'd0:    mag = 16'sd0;
            5'd1:    mag = 16'sd3212;
            5'd2:    mag = 16'sd6393;
            5'd3:    mag = 16'sd9512;
            5'd4:    mag = 16'sd12539;
            5'd5:    mag = 16'sd15446;
            5'd6:    mag = 16'sd18204;
            5'd7:    mag = 16'sd20787;
            5'd8:    mag = 16'sd23170;
            5'd9:    mag = 16'sd25329;
            5'd10:   mag = 16'sd27245;
            5'd11:   mag = 16'sd28898;
            5'd12:   mag = 16'sd30273;
            5'd13:   mag = 16'sd31356;
            5'd14:   mag = 16'sd32137;
            5'd15:   mag = 16'sd32609;
            default: mag = 16'sd32767;
        endcase
        return idx[5] ? -mag : mag;
    endfunction

    logic [31:0]         phase_q, phase_cur;
    logic [5:0]          idx_sin, idx_cos;
    logic signed [15:0]  x1, cos1, sin1;
    logic                v1, v2;
    logic signed [31:0]  prod_i, prod_q;
    logic signed [15:0]  pi2, pq2;
    logic [CW-1:0]       n_q;
    logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
    logic                q_first;
    logic                unused_bits;

    // The sample presented with sync always sees carrier phase 0.
    assign phase_cur = sync ? 32'd0 : phase_q;
    assign idx_sin   = phase_cur[31:26];
    assign idx_cos   = idx_sin + 6'd16;

    assign prod_i = x1 * cos1;
    assign prod_q = x1 * sin1;

    assign sum_i = acc_i + {{(ACC_W-16){pi2[15]}}, pi2};
    assign sum_q = acc_q + {{(ACC_W-16){pq2[15]}}, pq2};

    assign unused_bits = ^{msk_in[16:0], prod_i[31], prod_i[14:0], prod_q[31], prod_q[14:0]};

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            phase_q   <= '0;
            x1        <= '0;
            cos1      <= '0;
            sin1      <= '0;
            v1        <= 1'b0;
            pi2       <= '0;
            pq2       <= '0;
            v2        <= 1'b0;
            n_q       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            q_first   <= 1'b1;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            b_i       <= 1'b0;
            b_q       <= 1'b0;
        end else begin
            phase_q   <= phase_cur + PHASE_INC;
            x1        <= msk_in[32:17];
            cos1      <= sine(idx_cos);
            sin1      <= sine(idx_sin);
            v1        <= 1'b1;
            pi2       <= prod_i[30:15];
            pq2       <= prod_q[30:15];
            // The sample already in S1 belongs to the abandoned window.
            v2        <= v1 & ~sync;
            bit_valid <= 1'b0;
            if (sync) begin
                n_q     <= '0;
                acc_i   <= '0;
                acc_q   <= '0;
                q_first <= 1'b1;
            end else if (v2) begin
                n_q <= (n_q == CW'(WIN - 1)) ? '0 : n_q + CW'(1);
                if (n_q == CW'(WIN - 1)) begin
                    b_i       <= ~sum_i[ACC_W-1];
                    bit_out   <= ~sum_i[ACC_W-1];
                    bit_valid <= 1'b1;
                    acc_i     <= '0;
                end else begin
                    acc_i <= sum_i;
                end
                if (n_q == CW'(SPB - 1)) begin
                    acc_q <= '0;
                    if (q_first) begin
                        q_first <= 1'b0;
                    end else begin
                        b_q       <= ~sum_q[ACC_W-1];
                        bit_out   <= ~sum_q[ACC_W-1];
                        bit_valid <= 1'b1;
                    end
                end else begin
                    acc_q <= sum_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_msk_demod.sv
// Directed bench for msk_demod: reset, cos-carrier and negated streams, half-sine offset-keyed
// loop-back pattern, mid-window sync and reset just before a dump.
module tb_msk_demod;

    localparam int SPB      = 50;
    localparam int FIRST    = 2 * SPB + 2;
    localparam real PI      = 3.14159265358979;

    logic               clk = 1'b0;
    logic               reset;
    logic               sync;
    logic signed [32:0] msk_in;
    logic               bit_out, bit_valid, b_i, b_q;

    int n_checks = 0;
    int n_fail   = 0;
    int pat[8]   = '{1, 0, 1, 1, 0, 0, 1, 0};

    msk_demod #(
        .SPB      (SPB),
        .PHASE_INC(32'h4000_0000),
        .ACC_W    (24)
    ) dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .sync      (sync),
        .msk_in    (msk_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .b_i       (b_i),
        .b_q       (b_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        logic [63:0] r;
        r = {$urandom, $urandom};
        msk_in = r[32:0];
    endtask

    // mode 0: cos carrier, 1: negated cos carrier, 2: half-sine offset-keyed pattern stream.
    function automatic logic signed [32:0] sample(input int mode, input int s);
        real wi, wq, v;
        int  ai, aq;
        if (mode < 2) begin
            case (s % 4)
                0:       v = 1.0;
                2:       v = -1.0;
                default: v = 0.0;
            endcase
            if (mode == 1) v = -v;
            if (v > 0.5) return 33'sh0_8000_0000;
            if (v < -0.5) return -33'sh0_8000_0000;
            return '0;
        end
        ai = (pat[(2 * (s / 100)) % 8] != 0) ? 1 : -1;
        wi = $sin(PI * ((s % 100) + 0.5) / 100.0);
        if (s < 50) begin
            aq = 1;
            wq = $sin(PI * (s + 50.5) / 100.0);
        end else begin
            aq = (pat[(2 * ((s - 50) / 100) + 1) % 8] != 0) ? 1 : -1;
            wq = $sin(PI * (((s - 50) % 100) + 0.5) / 100.0);
        end
        case (s % 4)
            0:       v = ai * wi;
            1:       v = aq * wq;
            2:       v = -ai * wi;
            default: v = -aq * wq;
        endcase
        return 33'($rtoi(v * 1073741824.0));
    endfunction

    function automatic logic exp_bit(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 2 == 0) ? 1'b0 : 1'b1;
        return (pat[k % 8] != 0);
    endfunction

    // Drives a stream starting with a sync pulse and checks every strobe's timing and value.
    task automatic run_from_sync(input int mode, input int nedges, input bit chk_hold,
                                 input logic hold_i, input logic hold_q);
        int   next_edge;
        int   k;
        int   exp_cnt;
        logic eb;
        next_edge = FIRST;
        k = 0;
        for (int e = 0; e < nedges; e++) begin
            sync   = (e == 0);
            msk_in = sample(mode, e);
            step();
            if (chk_hold && e + 1 == FIRST - 1) begin
                check("hold_b_i", b_i, hold_i);
                check("hold_b_q", b_q, hold_q);
            end
            if (bit_valid) begin
                eb = exp_bit(mode, k);
                check("strobe_edge", e + 1, next_edge);
                check("bit_out", bit_out, eb);
                if (k % 2 == 0) check("b_i", b_i, eb);
                else check("b_q", b_q, eb);
                next_edge += SPB;
                k++;
            end
        end
        sync = 1'b0;
        exp_cnt = (nedges >= FIRST) ? (nedges - FIRST) / SPB + 1 : 0;
        check("strobe_count", k, exp_cnt);
    endtask

    initial begin
        int cnt;
        reset  = 1'b1;
        sync   = 1'b0;
        msk_in = '0;

        // 1: reset with random input, then no strobe before the first full I window
        repeat (5) begin
            rand_in();
            step();
        end
        check("rst_bit_out", bit_out, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_b_i", b_i, 0);
        check("rst_b_q", b_q, 0);
        reset = 1'b0;
        cnt = 0;
        for (int e = 1; e < FIRST; e++) begin
            rand_in();
            step();
            if (bit_valid) cnt++;
        end
        check("no_strobe_after_reset", cnt, 0);
        rand_in();
        step();
        check("first_strobe_after_reset", bit_valid, 1);

        // 2: cos carrier -> I = 1, Q = 1 (zero sum)
        run_from_sync(0, 400, 1'b0, 1'b0, 1'b0);
        // 3: negated -> I = 0, Q = 1
        run_from_sync(1, 400, 1'b0, 1'b0, 1'b0);
        // 5: sync 30 samples into an I window, prior decisions must hold
        run_from_sync(0, 2 * SPB * 2 + 30, 1'b0, 1'b0, 1'b0);
        run_from_sync(1, 160, 1'b1, 1'b1, 1'b1);
        // 4: loop-back pattern, 1000 bits
        run_from_sync(2, FIRST + 999 * SPB, 1'b0, 1'b0, 1'b0);
        check("lb_last_b_i", b_i, 1);
        check("lb_last_b_q", b_q, 0);

        // 6: reset on the edge of an I dump
        run_from_sync(0, FIRST - 1, 1'b0, 1'b0, 1'b0);
        reset  = 1'b1;
        msk_in = sample(0, FIRST - 1);
        step();
        check("rst_dump_bit_valid", bit_valid, 0);
        check("rst_dump_bit_out", bit_out, 0);
        check("rst_dump_b_i", b_i, 0);
        check("rst_dump_b_q", b_q, 0);
        reset = 1'b0;
        cnt = 0;
        for (int e = 0; e < 10; e++) begin
            msk_in = sample(0, e);
            step();
            if (bit_valid) cnt++;
        end
        check("rst_dump_no_strobe", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
